// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the MEM->WB consumer end.
//   GPR_ZERO  : index of the hardwired-zero register
//   DefDataW  : default register/data width
//   DefAddrW  : default register index width
//   gpr_idx_t : register index type at default width
//   word_t    : data word type at default width
package wb_regfile_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;

  localparam logic [DefAddrW-1:0] GPR_ZERO = 5'd0;

  typedef logic [DefAddrW-1:0] gpr_idx_t;
  typedef logic [DefDataW-1:0] word_t;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM->WB / ID-read / debug bundle of the register file.
//   master : pipeline side; drives WB-stage controls and data, ID read indices and
//            the debug index; receives read data, forwarded writeback value, debug
//            data and the retired-write count.
//   slave  : register-file side; the opposite directions.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
);

  // WB stage
  logic              WB_MemtoReg;
  logic              WB_RegWrite;
  logic [DATA_W-1:0] WB_rdata;
  logic [DATA_W-1:0] WB_ALU_res;
  logic [ADDR_W-1:0] WB_wreg;
  logic [DATA_W-1:0] WB_wdata;

  // ID stage read ports
  logic [ADDR_W-1:0] ID_rs;
  logic [ADDR_W-1:0] ID_rt;
  logic [DATA_W-1:0] ID_rdata1;
  logic [DATA_W-1:0] ID_rdata2;

  // Debug / trace
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [CNT_W-1:0]  wb_count;

  modport master (
    output WB_MemtoReg, WB_RegWrite, WB_rdata, WB_ALU_res, WB_wreg,
    output ID_rs, ID_rt, dbg_addr,
    input  WB_wdata, ID_rdata1, ID_rdata2, dbg_data, wb_count
  );

  modport slave (
    input  WB_MemtoReg, WB_RegWrite, WB_rdata, WB_ALU_res, WB_wreg,
    input  ID_rs, ID_rt, dbg_addr,
    output WB_wdata, ID_rdata1, ID_rdata2, dbg_data, wb_count
  );

endinterface

// File: rtl/wb_regfile_select.sv
// Writeback 2:1 select: load data or ALU result. Also reused by EX forwarding.
//   mem_to_reg_i : 1 selects rdata_i, 0 selects alu_res_i
//   rdata_i      : load data from MEM stage
//   alu_res_i    : ALU result
//   wdata_o      : selected writeback value (combinational)
module wb_select #(
  parameter int unsigned Width = 32
) (
  input  logic             mem_to_reg_i,
  input  logic [Width-1:0] rdata_i,
  input  logic [Width-1:0] alu_res_i,
  output logic [Width-1:0] wdata_o
);

  assign wdata_o = mem_to_reg_i ? rdata_i : alu_res_i;

endmodule

// File: rtl/wb_regfile.sv
// Writeback select plus the 2**ADDR_W entry GPR file.
//   clk : single clock, all state updates on posedge
//   rst : asynchronous active-high reset; clears GPRs, debug register and counter
//   bus : wb_regfile_if slave
//         - WB_* in  : writeback controls/data; WB_wdata out is the selected value
//         - ID_rs/ID_rt in, ID_rdata1/2 out : combinational reads, write-first bypass
//         - dbg_addr in, dbg_data out : registered read, 1-cycle latency, no bypass
//         - wb_count out : committed non-zero-register writes since reset (wraps)
// Storage is flop-based so that every entry clears on reset.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter bit          BYPASS_EN = 1'b1,
  parameter int unsigned CNT_W     = 32
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(GPR_ZERO);

  logic [DATA_W-1:0] wdata;
  logic              commit;

  logic [DATA_W-1:0] gpr_q [NumRegs];
  logic [DATA_W-1:0] dbg_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [ADDR_W-1:0] rd_idx  [2];
  logic [DATA_W-1:0] rd_data [2];

  wb_select #(
    .Width (DATA_W)
  ) u_wb_select (
    .mem_to_reg_i (bus.WB_MemtoReg),
    .rdata_i      (bus.WB_rdata),
    .alu_res_i    (bus.WB_ALU_res),
    .wdata_o      (wdata)
  );

  assign bus.WB_wdata = wdata;

  // Writes to the zero register are dropped entirely, including the count.
  assign commit = bus.WB_RegWrite && (bus.WB_wreg != ZeroIdx);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (commit) begin
      gpr_q[bus.WB_wreg] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (commit) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Samples storage before this edge's commit lands: pre-write contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_q <= '0;
    end else begin
      dbg_q <= (bus.dbg_addr == ZeroIdx) ? '0 : gpr_q[bus.dbg_addr];
    end
  end

  assign rd_idx[0] = bus.ID_rs;
  assign rd_idx[1] = bus.ID_rt;

  // Both ports resolve independently; rst forces zero even on the bypass path.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      if (!rst && (rd_idx[p] != ZeroIdx)) begin
        if (BYPASS_EN && bus.WB_RegWrite && (bus.WB_wreg == rd_idx[p])) begin
          rd_data[p] = wdata;
        end else begin
          rd_data[p] = gpr_q[rd_idx[p]];
        end
      end
    end
  end

  assign bus.ID_rdata1 = rd_data[0];
  assign bus.ID_rdata2 = rd_data[1];
  assign bus.dbg_data  = dbg_q;
  assign bus.wb_count  = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench: two DUTs share stimulus, one with bypass and a 32-bit counter,
// one without bypass and a 4-bit counter (to exercise wrap). The driver updates a
// reference model, drives inputs just after each posedge and queues the expected
// outputs; the monitor pops and compares on every negedge.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus_a ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus_b ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b1), .CNT_W(32)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b0), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct packed {
    logic     rst;
    logic     we;
    logic     m2r;
    word_t    rdata;
    word_t    alu;
    gpr_idx_t wreg;
    gpr_idx_t rs;
    gpr_idx_t rt;
    gpr_idx_t dbg;
  } stim_t;

  typedef struct {
    word_t       rd1_a;
    word_t       rd2_a;
    word_t       rd1_b;
    word_t       rd2_b;
    word_t       wdata;
    word_t       dbg;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;
  } exp_t;

  exp_t        sb_q [$];
  word_t       m_gpr [32];
  word_t       m_dbg;
  int unsigned m_commits;
  stim_t       cur;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic word_t ref_wdata();
    return cur.m2r ? cur.rdata : cur.alu;
  endfunction

  function automatic word_t ref_read(gpr_idx_t idx, bit bypass);
    if (cur.rst || idx == 0) return '0;
    if (bypass && cur.we && cur.wreg == idx) return ref_wdata();
    return m_gpr[idx];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_dbg     = '0;
    m_commits = 0;
  endtask

  // Effect of the clock edge that just happened, using the inputs held across it.
  task automatic model_edge();
    if (cur.rst) begin
      clear_model();
    end else begin
      m_dbg = (cur.dbg == 0) ? '0 : m_gpr[cur.dbg];
      if (cur.we && cur.wreg != 0) begin
        m_gpr[cur.wreg] = ref_wdata();
        m_commits++;
      end
    end
  endtask

  task automatic apply(stim_t s, bit push);
    exp_t e;
    cur = s;
    rst = s.rst;
    bus_a.WB_RegWrite = s.we;    bus_b.WB_RegWrite = s.we;
    bus_a.WB_MemtoReg = s.m2r;   bus_b.WB_MemtoReg = s.m2r;
    bus_a.WB_rdata    = s.rdata; bus_b.WB_rdata    = s.rdata;
    bus_a.WB_ALU_res  = s.alu;   bus_b.WB_ALU_res  = s.alu;
    bus_a.WB_wreg     = s.wreg;  bus_b.WB_wreg     = s.wreg;
    bus_a.ID_rs       = s.rs;    bus_b.ID_rs       = s.rs;
    bus_a.ID_rt       = s.rt;    bus_b.ID_rt       = s.rt;
    bus_a.dbg_addr    = s.dbg;   bus_b.dbg_addr    = s.dbg;
    // Asynchronous reset takes effect immediately, not at the next edge.
    if (s.rst) clear_model();
    if (push) begin
      e.rd1_a = ref_read(s.rs, 1'b1);
      e.rd2_a = ref_read(s.rt, 1'b1);
      e.rd1_b = ref_read(s.rs, 1'b0);
      e.rd2_b = ref_read(s.rt, 1'b0);
      e.wdata = ref_wdata();
      e.dbg   = m_dbg;
      e.cnt_a = m_commits;
      e.cnt_b = 4'(m_commits);
      sb_q.push_back(e);
    end
  endtask

  task automatic step(stim_t s);
    @(posedge clk);
    #1;
    model_edge();
    apply(s, 1'b1);
  endtask

  function automatic stim_t mk(logic r, logic we, logic m2r, word_t rdata, word_t alu,
                               gpr_idx_t wreg, gpr_idx_t rs, gpr_idx_t rt, gpr_idx_t dbg);
    stim_t s;
    s.rst = r; s.we = we; s.m2r = m2r; s.rdata = rdata; s.alu = alu;
    s.wreg = wreg; s.rs = rs; s.rt = rt; s.dbg = dbg;
    return s;
  endfunction

  function automatic stim_t rnd(bit allow_rst);
    stim_t s;
    s.rst   = allow_rst && ($urandom_range(0, 39) == 0);
    s.we    = ($urandom_range(0, 3) != 0);
    s.m2r   = 1'($urandom_range(0, 1));
    s.rdata = $urandom;
    s.alu   = $urandom;
    s.wreg  = 5'($urandom_range(0, 31));
    s.rs    = ($urandom_range(0, 2) == 0) ? s.wreg : 5'($urandom_range(0, 31));
    s.rt    = ($urandom_range(0, 2) == 0) ? s.wreg : 5'($urandom_range(0, 31));
    s.dbg   = 5'($urandom_range(0, 31));
    return s;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rdata1_byp",  bus_a.ID_rdata1, e.rd1_a);
        check("rdata2_byp",  bus_a.ID_rdata2, e.rd2_a);
        check("rdata1_nbyp", bus_b.ID_rdata1, e.rd1_b);
        check("rdata2_nbyp", bus_b.ID_rdata2, e.rd2_b);
        check("wb_wdata",    bus_a.WB_wdata,  e.wdata);
        check("dbg_data_a",  bus_a.dbg_data,  e.dbg);
        check("dbg_data_b",  bus_b.dbg_data,  e.dbg);
        check("wb_count_a",  bus_a.wb_count,  e.cnt_a);
        check("wb_count_b",  32'(bus_b.wb_count), 32'(e.cnt_b));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    clear_model();
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    // Basic commits from ALU result then load data.
    step(mk(0, 1, 0, 32'hFFFF_0000, 32'h1234, 5, 5, 0, 5));
    step(mk(0, 0, 0, 0, 0, 0, 5, 5, 5));
    step(mk(0, 1, 1, 32'hDEAD, 32'h5555, 5, 5, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 5, 0, 5));
    // Zero register is discarded.
    step(mk(0, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Same-cycle bypass on both ports; debug register shows the old value.
    step(mk(0, 1, 0, 0, 32'h1111, 7, 0, 0, 0));
    step(mk(0, 1, 0, 0, 32'hABCD, 7, 7, 7, 7));
    step(mk(0, 0, 0, 0, 0, 0, 7, 7, 7));
    step(mk(0, 0, 0, 0, 0, 0, 7, 7, 7));
    // Preload, then assert reset between edges while a write to r3 is pending.
    step(mk(0, 1, 0, 0, 32'h3333, 3, 3, 5, 3));
    step(mk(0, 1, 1, 32'h4444, 0, 9, 3, 9, 9));
    step(mk(1, 1, 0, 0, 32'h9999, 3, 3, 9, 3));
    step(mk(1, 0, 0, 0, 0, 0, 3, 9, 3));
    step(mk(0, 0, 0, 0, 0, 0, 3, 9, 3));
    step(mk(0, 0, 0, 0, 0, 0, 3, 5, 9));
    // Seventeen commits wrap the 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      step(mk(0, 1, 0, 0, $urandom, 5'(i % 31 + 1), 5'(i % 31 + 1), 0, 5'(i % 31)));
    end
    step(mk(0, 0, 0, 0, 0, 0, 1, 2, 3));
    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(rnd(1'b1));
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
